pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_if.sv | 27 ++
 rtl/pipe_scoreboard.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// Scoreboard entry, FSM state and forward-select encodings.
package pipe_pkg;

    localparam int SB_AW = 16;

    localparam int SB_WB  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_EX  = 2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FREEZE
    } hz_state_t;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic             load;
    } sb_entry_t;

    // x0 never matches: it is hard-wired zero
    function automatic logic sbHit(sb_entry_t e, logic [SB_AW-1:0] rs);
        return e.valid && (rs != '0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Link between the hazard FSM and its scoreboard.
// Master pushes/holds entries; slave returns per-source matches.
interface pipe_hazard_ctrl_if #(
    parameter int AW = 5
);
    import pipe_pkg::*;

    logic          hold;
    sb_entry_t     push;
    logic [AW-1:0] rsA;
    logic [AW-1:0] rsB;
    logic [2:0]    matchA;
    logic [2:0]    matchB;
    logic          ldHitA;
    logic          ldHitB;

    modport master (
        output hold, push, rsA, rsB,
        input  matchA, matchB, ldHitA, ldHitB
    );

    modport slave (
        input  hold, push, rsA, rsB,
        output matchA, matchB, ldHitA, ldHitB
    );

endinterface

// File: rtl/pipe_scoreboard.sv
// Three-entry EX/MEM/WB destination scoreboard.
// Shifts one stage per cycle unless held; reports source matches.
module pipe_scoreboard
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    pipe_hazard_ctrl_if.slave sb
);

    sb_entry_t        ent [3];
    logic [SB_AW-1:0] a;
    logic [SB_AW-1:0] b;

    assign a = SB_AW'(sb.rsA);
    assign b = SB_AW'(sb.rsB);

    // match vectors indexed EX/MEM/WB, plus load-in-EX hits
    always_comb begin
        sb.matchA = '0;
        sb.matchB = '0;
        for (int i = 0; i < 3; i++) begin
            sb.matchA[i] = sbHit(ent[i], a);
            sb.matchB[i] = sbHit(ent[i], b);
        end
        sb.ldHitA = sb.matchA[SB_EX] & ent[SB_EX].load;
        sb.ldHitB = sb.matchB[SB_EX] & ent[SB_EX].load;
    end

    // shift register of in-flight writers, frozen while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                ent[i] <= '0;
            end
        end else if (!sb.hold) begin
            ent[SB_WB]  <= ent[SB_MEM];
            ent[SB_MEM] <= ent[SB_EX];
            ent[SB_EX]  <= sb.push;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze FSM and forwarding.
// Define HAZARD_FWD_EN for MEM/WB forwarding with load-use stalls only.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_stall,
    output logic              ifd_stall,
    output logic              ifd_flush,
    output logic              ex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [SCNT_W-1:0] stall_cnt
);

    pipe_hazard_ctrl_if #(.AW(REG_AW)) sbIf ();

    pipe_scoreboard uSb (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbIf)
    );

    hz_state_t state;
    hz_state_t nextState;
    logic      blkA;
    logic      blkB;
    logic      hazard;

`ifdef HAZARD_FWD_EN
    // only a load still in EX cannot be forwarded in time
    assign blkA = sbIf.ldHitA;
    assign blkB = sbIf.ldHitB;

    // youngest producer (MEM) wins over WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (sbIf.matchA[SB_MEM]) begin
            fwd_a = FWD_MEM;
        end else if (sbIf.matchA[SB_WB]) begin
            fwd_a = FWD_WB;
        end
        if (sbIf.matchB[SB_MEM]) begin
            fwd_b = FWD_MEM;
        end else if (sbIf.matchB[SB_WB]) begin
            fwd_b = FWD_WB;
        end
    end
`else
    // every in-flight writer blocks until it leaves WB
    assign blkA = sbIf.ldHitA | (|sbIf.matchA);
    assign blkB = sbIf.ldHitB | (|sbIf.matchB);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    assign hazard = id_valid & (blkA | blkB);

    assign sbIf.rsA = id_rs_a;
    assign sbIf.rsB = id_rs_b;

    // stalled or flushed cycles push a bubble into EX
    assign sbIf.push.valid = id_valid & id_wr & ~ex_bubble;
    assign sbIf.push.rd    = SB_AW'(id_rd);
    assign sbIf.push.load  = id_load;

    // priority: mem_busy, then branch, then RAW hazard
    always_comb begin
        pc_stall  = 1'b0;
        ifd_stall = 1'b0;
        ifd_flush = 1'b0;
        ex_bubble = 1'b0;
        sbIf.hold = 1'b0;
        nextState = state;
        if (mem_busy) begin
            pc_stall  = 1'b1;
            ifd_stall = 1'b1;
            sbIf.hold = 1'b1;
            nextState = FREEZE;
        end else if (branch_taken) begin
            ifd_flush = 1'b1;
            ex_bubble = 1'b1;
            nextState = RUN;
        end else begin
            unique case (state)
                RUN:     if (hazard) nextState = STALL;
                STALL:   if (!hazard) nextState = RUN;
                FREEZE:  nextState = hazard ? STALL : RUN;
                default: nextState = RUN;
            endcase
            if (hazard) begin
                pc_stall  = 1'b1;
                ifd_stall = 1'b1;
                ex_bubble = 1'b1;
            end
        end
        if (!rst_n) begin
            pc_stall  = 1'b0;
            ifd_stall = 1'b0;
            ifd_flush = 1'b0;
            ex_bubble = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // saturating count of real stall cycles, frozen with the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!mem_busy && ifd_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Expected values are hand-derived for either HAZARD_FWD_EN build.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs_a;
    logic [4:0]  id_rs_b;
    logic [4:0]  id_rd;
    logic        id_wr;
    logic        id_load;
    logic        branch_taken;
    logic        mem_busy;
    logic        pc_stall;
    logic        ifd_stall;
    logic        ifd_flush;
    logic        ex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;

    int passCnt  = 0;
    int totalCnt = 0;
    int expCnt   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .SCNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs_a      (id_rs_a),
        .id_rs_b      (id_rs_b),
        .id_rd        (id_rd),
        .id_wr        (id_wr),
        .id_load      (id_load),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_stall     (pc_stall),
        .ifd_stall    (ifd_stall),
        .ifd_flush    (ifd_flush),
        .ex_bubble    (ex_bubble),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic chkOut(string tag, bit ps, bit is, bit fl, bit eb);
        chk({tag, ".pc_stall"}, 32'(pc_stall), 32'(ps));
        chk({tag, ".ifd_stall"}, 32'(ifd_stall), 32'(is));
        chk({tag, ".ifd_flush"}, 32'(ifd_flush), 32'(fl));
        chk({tag, ".ex_bubble"}, 32'(ex_bubble), 32'(eb));
    endtask

    task automatic drive(bit v, int ra, int rb, int rd,
                         bit wr, bit ld, bit br, bit busy);
        id_valid     = v;
        id_rs_a      = 5'(ra);
        id_rs_b      = 5'(rb);
        id_rd        = 5'(rd);
        id_wr        = wr;
        id_load      = ld;
        branch_taken = br;
        mem_busy     = busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 4, 5, 6, 1, 1, 1, 1);
        #3;
        chkOut("rst", 0, 0, 0, 0);
        chk("rst.cnt", 32'(stall_cnt), 0);
        chk("rst.fwd_a", 32'(fwd_a), 0);
        chk("rst.fwd_b", 32'(fwd_b), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef HAZARD_FWD_EN
        // add x5 then sub using x5: blocks through EX, MEM, WB
        tick();
        drive(1, 1, 2, 5, 1, 0, 0, 0);
        settle();
        chkOut("A0", 0, 0, 0, 0);
        tick();
        drive(1, 6, 5, 7, 1, 0, 0, 0);
        settle();
        chkOut("A1", 1, 1, 0, 1);
        chk("A1.fwd_b", 32'(fwd_b), 0);
        tick();
        settle();
        chkOut("A2", 1, 1, 0, 1);
        tick();
        settle();
        chkOut("A3", 1, 1, 0, 1);
        tick();
        settle();
        chkOut("A4", 0, 0, 0, 0);
        expCnt = 3;
        chk("A4.cnt", 32'(stall_cnt), 32'(expCnt));
        drain();
`else
        // load x3 then use: one load-use stall, then MEM forward
        tick();
        drive(1, 1, 2, 3, 1, 1, 0, 0);
        settle();
        chkOut("E0", 0, 0, 0, 0);
        tick();
        drive(1, 3, 0, 4, 1, 0, 0, 0);
        settle();
        chkOut("E1", 1, 1, 0, 1);
        tick();
        settle();
        chkOut("E2", 0, 0, 0, 0);
        chk("E2.fwd_a", 32'(fwd_a), 1);
        expCnt = 1;
        chk("E2.cnt", 32'(stall_cnt), 32'(expCnt));
        // two writers of x8: MEM beats WB, then WB alone
        tick();
        drive(1, 0, 0, 8, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 8, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8, 8, 0, 0, 0, 0, 0);
        settle();
        chk("E6.fwd_a", 32'(fwd_a), 1);
        chkOut("E6", 0, 0, 0, 0);
        tick();
        settle();
        chk("E7.fwd_b", 32'(fwd_b), 2);
        drain();
`endif

        // branch overrides a load-use hazard; flushed slot is empty
        drive(1, 1, 2, 9, 1, 1, 0, 0);
        settle();
        chkOut("B0", 0, 0, 0, 0);
        tick();
        drive(1, 9, 0, 10, 1, 0, 1, 0);
        settle();
        chkOut("B1", 0, 0, 1, 1);
        tick();
        drive(1, 10, 0, 11, 0, 0, 0, 0);
        settle();
        chkOut("B2", 0, 0, 0, 0);
        chk("B2.cnt", 32'(stall_cnt), 32'(expCnt));
        drain();

        // mem_busy during a stall freezes counter and scoreboard
        drive(1, 1, 2, 5, 1, 1, 0, 0);
        tick();
        drive(1, 6, 5, 7, 1, 0, 0, 0);
        settle();
        chkOut("C1", 1, 1, 0, 1);
        tick();
        expCnt++;
        for (int i = 0; i < 4; i++) begin
            drive(1, 6, 5, 7, 1, 0, 0, 1);
            settle();
            chkOut($sformatf("C%0d", i + 2), 1, 1, 0, 0);
            chk($sformatf("C%0d.cnt", i + 2), 32'(stall_cnt), 32'(expCnt));
            tick();
        end
        drive(1, 6, 5, 7, 1, 0, 0, 0);
        settle();
`ifndef HAZARD_FWD_EN
        chkOut("C6", 1, 1, 0, 1);
        chk("C6.cnt", 32'(stall_cnt), 32'(expCnt));
        tick();
        expCnt++;
        settle();
        chkOut("C7", 1, 1, 0, 1);
        tick();
        expCnt++;
        settle();
        chkOut("C8", 0, 0, 0, 0);
        chk("C8.cnt", 32'(stall_cnt), 32'(expCnt));
`else
        chkOut("C6", 0, 0, 0, 0);
        chk("C6.fwd_b", 32'(fwd_b), 1);
        chk("C6.cnt", 32'(stall_cnt), 32'(expCnt));
`endif
        drain();

        // async reset in the middle of a stall
        drive(1, 1, 2, 4, 1, 1, 0, 0);
        tick();
        drive(1, 4, 0, 5, 1, 0, 0, 0);
        settle();
        chkOut("D1", 1, 1, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chkOut("D.rst", 0, 0, 0, 0);
        chk("D.rst.cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        chkOut("D.rel", 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 0, 0);
        settle();
        chkOut("D.x0ld", 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 8, 1, 0, 0, 0);
        settle();
        chkOut("D.x0use", 0, 0, 0, 0);
        chk("D.fwd_a", 32'(fwd_a), 0);
        tick();
        settle();
        chk("D.cnt", 32'(stall_cnt), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
